// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush
// and an optional 2-entry skid buffer that keeps back-pressure off the input path.
module pipe_stage_reg #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_DATA = 5,
  parameter int unsigned REG_W    = 4,
  parameter int unsigned NUM_REG  = 3,
  parameter int unsigned CTRL_W   = 6,
  parameter int unsigned SKID     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_DATA*DATA_W-1:0] data_in,
  input  logic [NUM_REG*REG_W-1:0]   reg_in,
  input  logic [CTRL_W-1:0]          ctrl_in,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_DATA*DATA_W-1:0] data_out,
  output logic [NUM_REG*REG_W-1:0]   reg_out,
  output logic [CTRL_W-1:0]          ctrl_out
);

  localparam int unsigned DW = NUM_DATA * DATA_W;
  localparam int unsigned RW = NUM_REG * REG_W;

  typedef enum logic [1:0] {S_EMPTY, S_ONE, S_TWO} state_t;

  state_t            state;
  state_t            state_nx;
  logic              in_fire;
  logic              out_fire;
  logic              ld_in;
  logic              ld_from_skid;
  logic              ld_skid;
  logic [DW-1:0]     skid_data;
  logic [RW-1:0]     skid_reg;
  logic [CTRL_W-1:0] skid_ctrl;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Next-state and load-select decode; flush outranks every handshake event.
  always_comb begin
    state_nx     = state;
    ld_in        = 1'b0;
    ld_from_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nx = S_EMPTY;
    end else begin
      unique case (state)
        S_EMPTY: begin
          if (in_fire) begin
            state_nx = S_ONE;
            ld_in    = 1'b1;
          end
        end
        S_ONE: begin
          if (in_fire && out_fire) begin
            ld_in = 1'b1;
          end else if (out_fire) begin
            state_nx = S_EMPTY;
          end else if (in_fire) begin
            // Only reachable with the skid buffer present.
            state_nx = S_TWO;
            ld_skid  = 1'b1;
          end
        end
        S_TWO: begin
          if (out_fire) begin
            state_nx     = S_ONE;
            ld_from_skid = 1'b1;
          end
        end
        default: state_nx = S_EMPTY;
      endcase
    end
  end

  // Main entry drives the outputs; ctrl_out is zeroed whenever the stage empties.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_EMPTY;
      out_valid <= 1'b0;
      data_out  <= '0;
      reg_out   <= '0;
      ctrl_out  <= '0;
    end else begin
      state     <= state_nx;
      out_valid <= (state_nx != S_EMPTY);
      if (state_nx == S_EMPTY) begin
        ctrl_out <= '0;
      end else if (ld_in) begin
        data_out <= data_in;
        reg_out  <= reg_in;
        ctrl_out <= ctrl_in;
      end else if (ld_from_skid) begin
        data_out <= skid_data;
        reg_out  <= skid_reg;
        ctrl_out <= skid_ctrl;
      end
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      always_ff @(posedge clk) begin
        if (rst) begin
          skid_data <= '0;
          skid_reg  <= '0;
          skid_ctrl <= '0;
        end else if (ld_skid) begin
          skid_data <= data_in;
          skid_reg  <= reg_in;
          skid_ctrl <= ctrl_in;
        end
      end

      // Registered ready: no combinational path from out_ready.
      always_ff @(posedge clk) begin
        if (rst) begin
          in_ready <= 1'b1;
        end else begin
          in_ready <= (state_nx != S_TWO);
        end
      end
    end else begin : g_noskid
      assign skid_data = '0;
      assign skid_reg  = '0;
      assign skid_ctrl = '0;
      assign in_ready  = !out_valid || out_ready;
    end
  endgenerate

endmodule
